uart_rx_fifo: RTL and testbench

UART 8N1 receive front-end that consumes the serial line driven into quasi_main's uart_rx pin. It synchronises and samples the line, validates start and stop bits, and pushes each good byte into a first-word-fall-through FIFO. The SoC bus/UART register block drains the FIFO through a valid/read-enable handshake. Sticky error flags cover framing errors and overrun.

---
 rtl/uart_rx_fifo_if.sv | 13 +
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 tb/tb_uart_rx_fifo.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - read-side handshake between the UART receive FIFO and its consumer
interface uart_rx_fifo_if #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
   logic             rd_en;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic [CNT_W-1:0] fifo_count;

   modport master (input rd_en, output rd_data, rd_valid, fifo_count);
   modport slave  (output rd_en, input rd_data, rd_valid, fifo_count);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1 receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16,
   parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 err_clr,
   uart_rx_fifo_if.master       rd,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] HALF_LOAD = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] FULL_LOAD = BW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BRK   = 3'd4;

   logic          rx_m, rx_s;
   logic [2:0]    state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, pop, push, frame_set, wr_ok, ovr_set, stop_sample;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m     <= 1'b1;
         rx_s     <= 1'b1;
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  baud_cnt <= HALF_LOAD;
                  state    <= START;
               end
            end
            START: begin
               if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
               else if (rx_s) state <= IDLE;
               else begin
                  baud_cnt <= FULL_LOAD;
                  bit_idx  <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
               else begin
                  shift    <= {rx_s, shift[7:1]};
                  baud_cnt <= FULL_LOAD;
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
               else state <= rx_s ? IDLE : BRK;
            end
            // A line held low after a bad stop bit must go high before we re-arm.
            BRK:     if (rx_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign stop_sample = (state == STOP) && (baud_cnt == '0);
   assign push        = stop_sample && rx_s;
   assign frame_set   = stop_sample && !rx_s;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = rd.rd_en && !empty;
   assign wr_ok   = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (frame_set)    frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (ovr_set)      overrun <= 1'b1;
         else if (err_clr) overrun <= 1'b0;
      end
   end

   // Storage carries no reset; the empty gate below keeps stale bytes off rd_data.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[AW-1:0]] <= shift;
   end

   assign rd.rd_valid   = !empty;
   assign rd.rd_data    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   assign rd.fifo_count = CNT_W'(wr_ptr - rd_ptr);
   assign irq           = !empty | frame_err | overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with 16 clk/bit and a 4-deep FIFO
module tb_uart_rx_fifo;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst, rx, err_clr;
   logic frame_err, overrun, irq;

   uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) rd_if ();

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .err_clr   (err_clr),
      .rd        (rd_if.master),
      .frame_err (frame_err),
      .overrun   (overrun),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted pop is compared with the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && rd_if.rd_en && rd_if.rd_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no entry", rd_if.rd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rd_if.rd_data !== e) begin
               miscompares++;
               $display("FAIL pop_data: got 0x%0h, expected 0x%0h at %0t", rd_if.rd_data, e, $time);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Cycle c of the frame runs from just after edge c; the stop sample lands on edge 155.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at,
                             input int abort_at, input bit chk_lat);
      tick();
      for (int c = 0; c < 10 * CPB; c++) begin
         if (c == abort_at) return;
         if (c < CPB)           rx = 1'b0;
         else if (c < 9 * CPB)  rx = b[(c - CPB) / CPB];
         else                   rx = stop;
         rd_if.rd_en = (c == pop_at);
         if (chk_lat && c == 154) chk("latency_before", rd_if.rd_valid, 1'b0);
         if (chk_lat && c == 155) chk("latency_after", rd_if.rd_valid, 1'b1);
         tick();
      end
      rd_if.rd_en = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         chk("drain_valid", rd_if.rd_valid, 1'b1);
         rd_if.rd_en = 1'b1;
         tick();
         rd_if.rd_en = 1'b0;
         tick();
      end
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      err_clr = 1'b0;
      rd_if.rd_en = 1'b0;
      tick(3);
      chk("rst_valid", rd_if.rd_valid, 1'b0);
      chk("rst_data", rd_if.rd_data, 8'h00);
      chk("rst_count", rd_if.fifo_count, 0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      chk("rst_irq", irq, 1'b0);
      rst = 1'b0;
      tick(4);

      // 1: single byte, latency and pop
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
      rx = 1'b1;
      tick(2);
      chk("t1_count", rd_if.fifo_count, 1);
      chk("t1_data", rd_if.rd_data, 8'hA5);
      drain(1);
      chk("t1_count_after", rd_if.fifo_count, 0);
      chk("t1_valid_after", rd_if.rd_valid, 1'b0);
      chk("t1_ferr", frame_err, 1'b0);
      chk("t1_ovr", overrun, 1'b0);

      // 2: short glitch is ignored
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(30);
      chk("t2_count", rd_if.fifo_count, 0);
      chk("t2_ferr", frame_err, 1'b0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, -1, -1, 1'b0);
      rx = 1'b1;
      tick(4);
      chk("t2_count_frame", rd_if.fifo_count, 1);
      drain(1);

      // 3: framing error followed by a held-low line
      send_frame(8'h55, 1'b0, -1, -1, 1'b0);
      tick(40);
      rx = 1'b1;
      tick(40);
      chk("t3_ferr", frame_err, 1'b1);
      chk("t3_count", rd_if.fifo_count, 0);
      chk("t3_valid", rd_if.rd_valid, 1'b0);
      chk("t3_irq_set", irq, 1'b1);
      clear_err();
      chk("t3_ferr_clr", frame_err, 1'b0);
      chk("t3_irq_clr", irq, 1'b0);

      // 4: overrun on the fifth byte
      for (int i = 1; i <= 5; i++) begin
         if (i <= DEPTH) exp_q.push_back(8'(i));
         send_frame(8'(i), 1'b1, -1, -1, 1'b0);
         rx = 1'b1;
         tick(4);
      end
      chk("t4_count", rd_if.fifo_count, 4);
      chk("t4_ovr", overrun, 1'b1);
      drain(4);
      chk("t4_valid_after", rd_if.rd_valid, 1'b0);
      clear_err();
      chk("t4_ovr_clr", overrun, 1'b0);

      // 5: push and pop together while full
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(8'h10 + 8'(i));
         send_frame(8'h10 + 8'(i), 1'b1, -1, -1, 1'b0);
         rx = 1'b1;
         tick(4);
      end
      chk("t5_full", rd_if.fifo_count, 4);
      exp_q.push_back(8'h77);
      send_frame(8'h77, 1'b1, 154, -1, 1'b0);
      rx = 1'b1;
      tick(4);
      chk("t5_ovr", overrun, 1'b0);
      chk("t5_count", rd_if.fifo_count, 4);
      drain(4);
      chk("t5_valid_after", rd_if.rd_valid, 1'b0);

      // 6: reset mid-frame with two entries held
      exp_q.push_back(8'hAA);
      send_frame(8'hAA, 1'b1, -1, -1, 1'b0);
      rx = 1'b1;
      tick(4);
      exp_q.push_back(8'hBB);
      send_frame(8'hBB, 1'b1, -1, -1, 1'b0);
      rx = 1'b1;
      tick(4);
      send_frame(8'h5A, 1'b1, -1, 60, 1'b0);
      chk("t6_pre_count", rd_if.fifo_count, 2);
      rst = 1'b1;
      rx = 1'b1;
      #1;
      chk("t6_rst_valid", rd_if.rd_valid, 1'b0);
      chk("t6_rst_count", rd_if.fifo_count, 0);
      chk("t6_rst_data", rd_if.rd_data, 8'h00);
      chk("t6_rst_irq", irq, 1'b0);
      exp_q.delete();
      tick(3);
      rst = 1'b0;
      tick(4);
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, -1, -1, 1'b0);
      rx = 1'b1;
      tick(4);
      chk("t6_count", rd_if.fifo_count, 1);
      chk("t6_data", rd_if.rd_data, 8'hC3);
      drain(1);
      chk("t6_valid_after", rd_if.rd_valid, 1'b0);
      chk("t6_flags", {frame_err, overrun}, 2'b00);
      chk("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
